// File: rtl/gbf_flgact_reader_pkg.sv
// Shared types and default geometry for the activation-flag global-buffer reader.
package gbf_flgact_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int unsigned DEF_SRAM_DEPTH_BIT = 6;
   localparam int unsigned DEF_SRAM_WIDTH     = 28;
   localparam int unsigned DEF_BUF_DEPTH      = 3;

endpackage

// File: rtl/gbf_flgact_reader_out_fifo.sv
// Small synchronous FIFO holding returned flag words (plus last tag) for the output stream.
module flgact_out_fifo #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned WIDTH = 29
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_push,
   input  logic [WIDTH-1:0]               i_din,
   input  logic                           i_pop,
   output logic [WIDTH-1:0]               o_dout,
   output logic [$clog2(DEPTH+1)-1:0]     o_count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (i_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/gbf_flgact_reader.sv
// Streams cfg_len flag words from the flag RAM to the PE-array decoder, hiding read latency.
module gbf_flgact_reader
   import gbf_flgact_reader_pkg::*;
#(
   parameter int unsigned SRAM_DEPTH_BIT = DEF_SRAM_DEPTH_BIT,
   parameter int unsigned SRAM_DEPTH     = 2 ** SRAM_DEPTH_BIT,
   parameter int unsigned SRAM_WIDTH     = DEF_SRAM_WIDTH,
   parameter int unsigned BUF_DEPTH      = DEF_BUF_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_start,
   input  logic [SRAM_DEPTH_BIT-1:0]   cfg_base_addr,
   input  logic [SRAM_DEPTH_BIT:0]     cfg_len,
   output logic                        busy,
   output logic                        done,
   input  logic                        ram_write_en,
   output logic                        ram_read_en,
   output logic [SRAM_DEPTH_BIT-1:0]   ram_addr_r,
   input  logic [SRAM_WIDTH-1:0]       ram_data_out,
   output logic                        flg_vld,
   input  logic                        flg_rdy,
   output logic [SRAM_WIDTH-1:0]       flg_data,
   output logic                        flg_last
);

   localparam int unsigned AW = SRAM_DEPTH_BIT;
   localparam int unsigned LW = SRAM_DEPTH_BIT + 1;
   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

   state_t          r_state, w_next_state;
   logic [AW-1:0]   r_rd_addr;
   logic [LW-1:0]   r_remaining;
   logic            r_inflight;
   logic            r_inflight_last;

   logic [CW-1:0]   w_count;
   logic [CW:0]     w_occupancy;
   logic [SRAM_WIDTH:0] w_head;
   logic            w_issue;
   logic            w_issue_last;
   logic            w_pop;
   logic            w_pop_last;
   logic [AW-1:0]   w_addr_inc;

   // Credit includes the read still in flight so the returning word always has a slot.
   assign w_occupancy  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
   assign w_issue      = (r_state == ST_RUN) && (r_remaining != '0) && !ram_write_en
                         && (w_occupancy < (CW+1)'(BUF_DEPTH));
   assign w_issue_last = w_issue && (r_remaining == LW'(1));
   assign w_pop        = flg_vld && flg_rdy;
   assign w_pop_last   = w_pop && flg_last;
   assign w_addr_inc   = (r_rd_addr == AW'(SRAM_DEPTH - 1)) ? '0 : r_rd_addr + AW'(1);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (cfg_start) w_next_state = (cfg_len == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (w_issue_last) w_next_state = w_pop_last ? ST_DONE : ST_DRAIN;
         ST_DRAIN: if (w_pop_last) w_next_state = ST_DONE;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_rd_addr       <= '0;
         r_remaining     <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue_last;
         if (r_state == ST_IDLE && cfg_start) begin
            r_rd_addr   <= cfg_base_addr;
            r_remaining <= cfg_len;
         end else if (w_issue) begin
            r_rd_addr   <= w_addr_inc;
            r_remaining <= r_remaining - LW'(1);
         end
      end
   end

   flgact_out_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (SRAM_WIDTH + 1)
   ) u_out_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_inflight),
      .i_din   ({r_inflight_last, ram_data_out}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_count (w_count)
   );

   assign busy        = (r_state != ST_IDLE);
   assign done        = (r_state == ST_DONE);
   assign ram_read_en = w_issue;
   assign ram_addr_r  = r_rd_addr;
   assign flg_vld     = (w_count != '0);
   assign flg_data    = w_head[SRAM_WIDTH-1:0];
   assign flg_last    = w_head[SRAM_WIDTH];

endmodule
